// File: rtl/imem_line_server_pkg.sv
// Shared constants for the instruction-memory line server: word/line geometry and FSM encodings.
package imem_line_server_pkg;

    localparam int unsigned WORD_SIZE        = 32;
    localparam int unsigned WORDS_PER_LINE   = 4;
    localparam int unsigned ICACHE_LINE_SIZE = WORD_SIZE * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_BUSY = 2'd1,
        IMEM_RESP = 2'd2,
        IMEM_HOLD = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_word_array.sv
// Word-addressed backing store: one synchronous write port, one combinational 4-word line read.
module imem_word_array
    import imem_line_server_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [ADDR_W-1:0]           waddr_i,
    input  logic [WORD_SIZE-1:0]        wdata_i,
    input  logic [ADDR_W-3:0]           line_idx_i,
    output logic [ICACHE_LINE_SIZE-1:0] line_o
);

    // Contents survive reset on purpose: a program load must outlive a core reset.
    logic [WORD_SIZE-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        line_o = '0;
        for (int k = 0; k < int'(WORDS_PER_LINE); k++) begin
            line_o[k*WORD_SIZE +: WORD_SIZE] = mem_q[{line_idx_i, 2'(k)}];
        end
    end

endmodule

// File: rtl/imem_line_server.sv
// Serves 4-word instruction-cache line fills after a fixed latency; loadable backing store.
module imem_line_server
    import imem_line_server_pkg::*;
#(
    parameter int unsigned MEM_LATENCY     = 5,
    parameter int unsigned MEM_DEPTH_WORDS = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        MemRead,
    input  logic [WORD_SIZE-1:0]        PCMem,
    input  logic                        LoadEn,
    input  logic [WORD_SIZE-1:0]        LoadAddr,
    input  logic [WORD_SIZE-1:0]        LoadData,
    output logic [ICACHE_LINE_SIZE-1:0] MemLine,
    output logic                        MemReady
);

    localparam int unsigned AW    = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned LW    = AW - 2;
    localparam int unsigned LINES = MEM_DEPTH_WORDS / WORDS_PER_LINE;

    imem_state_e                 state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [LW-1:0]               idx_q, idx_d;
    logic                        ready_q, ready_d;
    logic [ICACHE_LINE_SIZE-1:0] line_q, line_d;
    logic [ICACHE_LINE_SIZE-1:0] rd_line;
    logic [LW-1:0]               req_idx;
    logic [AW-1:0]               load_word;
    logic                        unused_addr_bits;

    assign req_idx          = LW'(32'(PCMem[WORD_SIZE-1:4]) % LINES);
    assign load_word        = AW'(32'(LoadAddr[WORD_SIZE-1:2]) % MEM_DEPTH_WORDS);
    assign unused_addr_bits = ^{PCMem[3:0], LoadAddr[1:0]};

    imem_word_array #(
        .DEPTH_WORDS (MEM_DEPTH_WORDS)
    ) u_array (
        .clk_i      (clk),
        .we_i       (LoadEn),
        .waddr_i    (load_word),
        .wdata_i    (LoadData),
        .line_idx_i (idx_q),
        .line_o     (rd_line)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        line_d  = line_q;
        unique case (state_q)
            IMEM_IDLE: begin
                if (MemRead) begin
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    state_d = IMEM_BUSY;
                end
            end
            IMEM_BUSY: begin
                // Abort wins even on the final latency cycle: no pulse for a dropped request.
                if (!MemRead) begin
                    cnt_d   = '0;
                    state_d = IMEM_IDLE;
                end else if (cnt_q == 4'(MEM_LATENCY - 1)) begin
                    line_d  = rd_line;
                    ready_d = 1'b1;
                    state_d = IMEM_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IMEM_RESP: state_d = IMEM_HOLD;
            IMEM_HOLD: begin
                if (!MemRead) begin
                    state_d = IMEM_IDLE;
                end
            end
            default: state_d = IMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            line_q  <= line_d;
        end
    end

    assign MemLine  = line_q;
    assign MemReady = ready_q;

endmodule

// File: tb/tb_imem_line_server.sv
// Directed self-checking bench for imem_line_server: latency 5 instance plus a latency 1 instance.
module tb_imem_line_server;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         MemRead = 1'b0, LoadEn = 1'b0;
    logic [31:0]  PCMem = '0, LoadAddr = '0, LoadData = '0;
    logic [127:0] MemLine;
    logic         MemReady;

    logic         mr1 = 1'b0, le1 = 1'b0;
    logic [31:0]  pc1 = '0, la1 = '0, ld1 = '0;
    logic [127:0] line1;
    logic         ready1;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] L40  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L40B = 128'h44444444_33333333_22222222_55555555;
    localparam logic [127:0] L0   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] L1A  = 128'hB3B3B3B3_B2B2B2B2_C1C1C1C1_B0B0B0B0;
    localparam logic [127:0] L1C  = 128'hB3B3B3B3_D2D2D2D2_C1C1C1C1_B0B0B0B0;

    imem_line_server #(.MEM_LATENCY(5), .MEM_DEPTH_WORDS(4096)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .PCMem(PCMem), .LoadEn(LoadEn),
        .LoadAddr(LoadAddr), .LoadData(LoadData), .MemLine(MemLine), .MemReady(MemReady)
    );

    imem_line_server #(.MEM_LATENCY(1), .MEM_DEPTH_WORDS(4096)) dut1 (
        .clk(clk), .rst(rst), .MemRead(mr1), .PCMem(pc1), .LoadEn(le1),
        .LoadAddr(la1), .LoadData(ld1), .MemLine(line1), .MemReady(ready1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        step();
        LoadEn = 1'b0;
    endtask

    task automatic load1(input logic [31:0] a, input logic [31:0] d);
        le1 = 1'b1; la1 = a; ld1 = d;
        step();
        le1 = 1'b0;
    endtask

    // Accept, scramble PCMem (must be ignored), expect the pulse exactly 5 edges after acceptance.
    task automatic do_request(input logic [31:0] pc, input logic [127:0] exp, input string tag);
        MemRead = 1'b1; PCMem = pc;
        step();
        PCMem = 32'hDEADBEEF;
        for (int i = 1; i < 5; i++) begin
            step();
            chk1({tag, "_early"}, MemReady, 1'b0);
        end
        step();
        chk1({tag, "_ready"}, MemReady, 1'b1);
        chkl({tag, "_line"}, MemLine, exp);
    endtask

    task automatic release_req();
        MemRead = 1'b0;
        step();
        step();
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        chk1("rst_ready", MemReady, 1'b0);
        chkl("rst_line", MemLine, '0);
        step();
        step();
        rst = 1'b1;

        load(32'h40, 32'h11111111);
        load(32'h44, 32'h22222222);
        load(32'h48, 32'h33333333);
        load(32'h4C, 32'h44444444);
        load(32'h00, 32'hA0A0A0A0);
        load(32'h04, 32'hA1A1A1A1);
        load(32'h08, 32'hA2A2A2A2);
        load(32'h0C, 32'hA3A3A3A3);
        load1(32'h80, 32'hB0B0B0B0);
        load1(32'h84, 32'hB1B1B1B1);
        load1(32'h88, 32'hB2B2B2B2);
        load1(32'h8C, 32'hB3B3B3B3);

        do_request(32'h48, L40, "basic");
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("hold_single_pulse", MemReady, 1'b0);
        end
        chkl("hold_line_stable", MemLine, L40);
        release_req();
        do_request(32'h0, L0, "second");
        release_req();

        MemRead = 1'b1; PCMem = 32'h40;
        step();
        step();
        step();
        MemRead = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("abort_no_ready", MemReady, 1'b0);
        end
        chkl("abort_line_kept", MemLine, L0);
        do_request(32'h44, L40, "after_abort");
        release_req();

        load(32'h40, 32'h55555555);
        do_request(32'h4048, L40B, "wrap");
        release_req();

        MemRead = 1'b1; PCMem = 32'h0;
        step();
        step();
        step();
        rst = 1'b0;
        MemRead = 1'b0;
        #1;
        chk1("midreq_rst_ready", MemReady, 1'b0);
        chkl("midreq_rst_line", MemLine, '0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1("post_rst_no_ready", MemReady, 1'b0);
        end
        chkl("post_rst_line_zero", MemLine, '0);
        do_request(32'h0, L0, "post_rst");
        release_req();

        // Latency 1: load on the acceptance edge is seen by the read on the next edge.
        mr1 = 1'b1; pc1 = 32'h80; le1 = 1'b1; la1 = 32'h84; ld1 = 32'hC1C1C1C1;
        step();
        le1 = 1'b0;
        chk1("lat1_accept_no_ready", ready1, 1'b0);
        step();
        chk1("lat1_a_ready", ready1, 1'b1);
        chkl("lat1_a_line", line1, L1A);
        mr1 = 1'b0;
        step();
        chk1("lat1_a_pulse_end", ready1, 1'b0);
        step();

        // Load on the read edge itself must return the old word.
        mr1 = 1'b1; pc1 = 32'h80;
        step();
        le1 = 1'b1; la1 = 32'h88; ld1 = 32'hD2D2D2D2;
        step();
        le1 = 1'b0;
        chk1("lat1_b_ready", ready1, 1'b1);
        chkl("lat1_b_line_old", line1, L1A);
        mr1 = 1'b0;
        step();
        step();
        mr1 = 1'b1;
        step();
        step();
        chk1("lat1_c_ready", ready1, 1'b1);
        chkl("lat1_c_line_new", line1, L1C);
        mr1 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
